// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory responder: word-organised RAM with programmable wait
// states, two-cycle ERROR responses and byte-lane writes.
// Little-endian lanes: byte n of a word is carried on HWDATA/HRDATA[8n+7:8n].
// The lane logic assumes a 32-bit data bus (four byte lanes).
module ahb_slave_mem #(
    parameter int Width       = 32,
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic             HWRITE,
    input  logic [2:0]       HSIZE,
    input  logic [2:0]       HBURST,
    input  logic [1:0]       HTRANS,
    input  logic             HREADY,
    input  logic [Width-1:0] HWDATA,
    output logic [Width-1:0] HRDATA,
    output logic             HREADYOUT,
    output logic             HRESP
);

    localparam int NumLanes = Width / 8;
    localparam int NumWords = (2 ** ADDR_BITS) / NumLanes;
    localparam int IdxBits  = ADDR_BITS - 2;
    localparam logic [2:0] WaitLoad = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        DATA,
        ERR1,
        ERR2
    } stateT;

    stateT                 state;
    logic [IdxBits-1:0]    wordIdx;
    logic                  writeReg;
    logic [NumLanes-1:0]   laneMask;
    logic [2:0]            waitCnt;
    logic [Width-1:0]      mem [NumWords];

    logic                  accept;
    logic                  reqBad;
    logic [NumLanes-1:0]   reqMask;
    logic                  writeNow;
    logic [IdxBits-1:0]    readIdx;
    logic [Width-1:0]      readWord;

    // Burst type and the BUSY/IDLE distinction carry no meaning for this memory.
    logic unusedBits;
    assign unusedBits = ^{HBURST, HTRANS[0]};

    // Decode the address phase on the bus and build the forwarded read word.
    // A read accepted on the same edge that completes a write to the same word
    // must see the new bytes, so HWDATA is merged lane by lane over the RAM word.
    always_comb begin
        accept   = (state == IDLE || state == DATA || state == ERR2)
                   && HSEL && HREADY && HTRANS[1];
        reqMask  = '0;
        case (HSIZE)
            3'b000:  reqMask[HADDR[1:0]] = 1'b1;
            3'b001:  reqMask = HADDR[1] ? 4'b1100 : 4'b0011;
            default: reqMask = 4'b1111;
        endcase
        reqBad   = (HSIZE > 3'b010)
                   || (HSIZE == 3'b001 && HADDR[0])
                   || (HSIZE == 3'b010 && HADDR[1:0] != 2'b00)
                   || (HADDR[31:ADDR_BITS] != '0);
        writeNow = (state == DATA) && writeReg;
        readIdx  = (state == WAIT) ? wordIdx : HADDR[ADDR_BITS-1:2];
        readWord = mem[readIdx];
        if (writeNow && readIdx == wordIdx) begin
            for (int i = 0; i < NumLanes; i++) begin
                if (laneMask[i]) begin
                    readWord[8*i +: 8] = HWDATA[8*i +: 8];
                end
            end
        end
    end

    // Transfer FSM with registered HREADYOUT/HRESP/HRDATA.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state     <= IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            wordIdx   <= '0;
            writeReg  <= 1'b0;
            laneMask  <= '0;
            waitCnt   <= '0;
        end else begin
            case (state)
                WAIT: begin
                    if (waitCnt == 3'd0) begin
                        state     <= DATA;
                        HREADYOUT <= 1'b1;
                        if (!writeReg) begin
                            HRDATA <= readWord;
                        end
                    end else begin
                        waitCnt <= waitCnt - 3'd1;
                    end
                end
                ERR1: begin
                    state     <= ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                default: begin
                    if (accept) begin
                        wordIdx  <= HADDR[ADDR_BITS-1:2];
                        laneMask <= reqMask;
                        if (reqBad) begin
                            state     <= ERR1;
                            writeReg  <= 1'b0;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b1;
                        end else if (WAIT_STATES == 0) begin
                            state     <= DATA;
                            writeReg  <= HWRITE;
                            HREADYOUT <= 1'b1;
                            HRESP     <= 1'b0;
                            if (!HWRITE) begin
                                HRDATA <= readWord;
                            end
                        end else begin
                            state     <= WAIT;
                            writeReg  <= HWRITE;
                            waitCnt   <= WaitLoad;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b0;
                        end
                    end else begin
                        state     <= IDLE;
                        writeReg  <= 1'b0;
                        HREADYOUT <= 1'b1;
                        HRESP     <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Commit write data on the edge that ends a write data phase; unselected
    // lanes keep their old contents and reset suppresses the write.
    always_ff @(posedge HCLK) begin
        if (HRESETn && writeNow) begin
            for (int i = 0; i < NumLanes; i++) begin
                if (laneMask[i]) begin
                    mem[wordIdx][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Testbench for ahb_slave_mem: a pipelined AHB master drives beat lists into
// one of two responders (one wait state / zero wait states), and a scoreboard
// of expected responses is popped as each data phase completes.
module tb_ahb_slave_mem;

    localparam logic [1:0] HtIdle   = 2'b00;
    localparam logic [1:0] HtBusy   = 2'b01;
    localparam logic [1:0] HtNonseq = 2'b10;
    localparam logic [1:0] HtSeq    = 2'b11;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        busSel;
    logic        useFast;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic        selA, selB;
    logic [31:0] rdataA, rdataB;
    logic        rdyA, rdyB, respA, respB;

    typedef struct {
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beatT;

    typedef struct {
        logic        dataCheck;
        logic [31:0] rdata;
        logic        resp;
        int          stalls;
        int          id;
    } expT;

    beatT        beatQ[$];
    expT         sbQ[$];
    logic [31:0] modelMem [2][256];
    int          beatIdx;
    bit          addrPending;
    int          checks = 0;
    int          passed = 0;

    // Free-running bus clock.
    always #5 HCLK = ~HCLK;

    assign selA   = busSel & ~useFast;
    assign selB   = busSel & useFast;
    assign HREADY = useFast ? rdyB : rdyA;

    ahb_slave_mem #(.Width(32), .ADDR_BITS(10), .WAIT_STATES(1)) dutA (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(selA), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HREADY(HREADY),
        .HWDATA(HWDATA), .HRDATA(rdataA), .HREADYOUT(rdyA), .HRESP(respA)
    );

    ahb_slave_mem #(.Width(32), .ADDR_BITS(10), .WAIT_STATES(0)) dutB (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(selB), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HREADY(HREADY),
        .HWDATA(HWDATA), .HRDATA(rdataB), .HREADYOUT(rdyB), .HRESP(respB)
    );

    task automatic idleBus();
        busSel = 1'b0;
        HTRANS = HtIdle;
        HADDR  = '0;
        HWRITE = 1'b0;
        HSIZE  = 3'b010;
        HBURST = 3'b000;
    endtask

    task automatic addBeat(input logic [1:0] trans, input logic write, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
        beatT b;
        b.trans = trans;
        b.write = write;
        b.size  = size;
        b.addr  = addr;
        b.wdata = wdata;
        beatQ.push_back(b);
    endtask

    // Model the response of a beat as it is put on the bus and queue it.
    task automatic pushExpect(input beatT b);
        expT  e;
        int   m;
        int   wi;
        logic legal;
        logic sel;
        m = useFast ? 1 : 0;
        e.dataCheck = 1'b0;
        e.rdata     = '0;
        e.resp      = 1'b0;
        e.stalls    = 0;
        e.id        = beatIdx;
        legal = (b.size <= 3'd2) && !(b.size == 3'd1 && b.addr[0])
                && !(b.size == 3'd2 && b.addr[1:0] != 2'b00) && (b.addr[31:10] == 22'd0);
        if (b.trans[1]) begin
            if (!legal) begin
                e.resp   = 1'b1;
                e.stalls = 1;
            end else begin
                e.stalls = useFast ? 0 : 1;
                wi = int'(b.addr[9:2]);
                if (b.write) begin
                    for (int l = 0; l < 4; l++) begin
                        if (b.size == 3'd0)      sel = (l == int'(b.addr[1:0]));
                        else if (b.size == 3'd1) sel = ((l / 2) == int'(b.addr[1]));
                        else                     sel = 1'b1;
                        if (sel) modelMem[m][wi][8*l +: 8] = b.wdata[8*l +: 8];
                    end
                end else begin
                    e.dataCheck = 1'b1;
                    e.rdata     = modelMem[m][wi];
                end
            end
        end
        sbQ.push_back(e);
    endtask

    task automatic putNext();
        beatT b;
        if (beatIdx < beatQ.size()) begin
            b      = beatQ[beatIdx];
            busSel = 1'b1;
            HTRANS = b.trans;
            HWRITE = b.write;
            HSIZE  = b.size;
            HADDR  = b.addr;
            HBURST = (b.trans == HtNonseq) ? 3'b000 : 3'b001;
            pushExpect(b);
            addrPending = 1'b1;
            beatIdx++;
        end else begin
            idleBus();
            addrPending = 1'b0;
        end
    endtask

    // Pipelined master: address of beat n+1 overlaps the data phase of beat n.
    task automatic runBeats();
        int          cycles = 0;
        int          stallCnt = 0;
        bit          dpValid = 1'b0;
        logic        hr, rsp;
        logic [31:0] rd;
        beatIdx = 0;
        @(negedge HCLK);
        putNext();
        while ((addrPending || dpValid) && cycles < 200) begin
            hr  = HREADY;
            rsp = useFast ? respB : respA;
            rd  = useFast ? rdataB : rdataA;
            if (dpValid) begin
                if (!hr) begin
                    stallCnt++;
                    checks++;
                    if (rsp !== sbQ[0].resp)
                        $display("[TB] FAIL stall_resp beat %0d: got %b want %b", sbQ[0].id, rsp, sbQ[0].resp);
                    else passed++;
                end else begin
                    checks++;
                    if (stallCnt !== sbQ[0].stalls)
                        $display("[TB] FAIL stall_count beat %0d: got %0d want %0d", sbQ[0].id, stallCnt, sbQ[0].stalls);
                    else passed++;
                    checks++;
                    if (rsp !== sbQ[0].resp)
                        $display("[TB] FAIL final_resp beat %0d: got %b want %b", sbQ[0].id, rsp, sbQ[0].resp);
                    else passed++;
                    if (sbQ[0].dataCheck) begin
                        checks++;
                        if (rd !== sbQ[0].rdata)
                            $display("[TB] FAIL read_data beat %0d: got %h want %h", sbQ[0].id, rd, sbQ[0].rdata);
                        else passed++;
                    end
                    sbQ.delete(0);
                end
            end
            @(posedge HCLK);
            #1;
            if (hr) begin
                dpValid  = addrPending;
                stallCnt = 0;
                if (addrPending) HWDATA = beatQ[beatIdx-1].wdata;
                putNext();
            end
            @(negedge HCLK);
            cycles++;
        end
        if (addrPending || dpValid) begin
            checks++;
            $display("[TB] FAIL transfer_timeout: got %0d pending beats want 0", sbQ.size());
        end
        beatQ.delete();
        sbQ.delete();
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        useFast = 1'b0;
        HWDATA  = '0;
        idleBus();
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        checks += 6;
        if (rdyA !== 1'b1) $display("[TB] FAIL reset_readyA: got %b want 1", rdyA); else passed++;
        if (respA !== 1'b0) $display("[TB] FAIL reset_respA: got %b want 0", respA); else passed++;
        if (rdataA !== 32'h0) $display("[TB] FAIL reset_rdataA: got %h want 0", rdataA); else passed++;
        if (rdyB !== 1'b1) $display("[TB] FAIL reset_readyB: got %b want 1", rdyB); else passed++;
        if (respB !== 1'b0) $display("[TB] FAIL reset_respB: got %b want 0", respB); else passed++;
        if (rdataB !== 32'h0) $display("[TB] FAIL reset_rdataB: got %h want 0", rdataB); else passed++;
        HRESETn = 1'b1;
        addBeat(HtNonseq, 1'b1, 3'b010, 32'h30, 32'h12345678);
        addBeat(HtNonseq, 1'b0, 3'b010, 32'h30, 32'h0);
        runBeats();
        // start a write, then reset across its data phase
        busSel = 1'b1;
        HTRANS = HtNonseq;
        HWRITE = 1'b1;
        HSIZE  = 3'b010;
        HADDR  = 32'h30;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b0;
        HWDATA  = 32'hBAD0BAD0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        checks += 3;
        if (rdyA !== 1'b1) $display("[TB] FAIL midreset_ready: got %b want 1", rdyA); else passed++;
        if (respA !== 1'b0) $display("[TB] FAIL midreset_resp: got %b want 0", respA); else passed++;
        if (rdataA !== 32'h0) $display("[TB] FAIL midreset_rdata: got %h want 0", rdataA); else passed++;
        idleBus();
        HRESETn = 1'b1;
        addBeat(HtNonseq, 1'b0, 3'b010, 32'h30, 32'h0);
        runBeats();
    endtask

    task automatic test_word_rw();
        useFast = 1'b0;
        addBeat(HtNonseq, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        addBeat(HtNonseq, 1'b0, 3'b010, 32'h10, 32'h0);
        runBeats();
    endtask

    task automatic test_byte_lanes();
        useFast = 1'b0;
        addBeat(HtNonseq, 1'b1, 3'b010, 32'h10, 32'h11223344);
        addBeat(HtNonseq, 1'b1, 3'b000, 32'h13, 32'hAA555555);
        addBeat(HtNonseq, 1'b0, 3'b010, 32'h10, 32'h0);
        addBeat(HtNonseq, 1'b1, 3'b010, 32'h14, 32'hFFFFFFFF);
        addBeat(HtNonseq, 1'b1, 3'b001, 32'h16, 32'h12349999);
        addBeat(HtNonseq, 1'b0, 3'b010, 32'h14, 32'h0);
        runBeats();
    endtask

    task automatic test_burst();
        useFast = 1'b0;
        addBeat(HtIdle,   1'b0, 3'b010, 32'h20, 32'h0);
        addBeat(HtNonseq, 1'b1, 3'b010, 32'h20, 32'h1);
        addBeat(HtSeq,    1'b1, 3'b010, 32'h24, 32'h2);
        addBeat(HtBusy,   1'b1, 3'b010, 32'h28, 32'h0);
        addBeat(HtSeq,    1'b1, 3'b010, 32'h28, 32'h3);
        addBeat(HtSeq,    1'b1, 3'b010, 32'h2C, 32'h4);
        addBeat(HtNonseq, 1'b0, 3'b010, 32'h20, 32'h0);
        addBeat(HtSeq,    1'b0, 3'b010, 32'h24, 32'h0);
        addBeat(HtSeq,    1'b0, 3'b010, 32'h28, 32'h0);
        addBeat(HtSeq,    1'b0, 3'b010, 32'h2C, 32'h0);
        runBeats();
    endtask

    task automatic test_error();
        useFast = 1'b0;
        addBeat(HtNonseq, 1'b1, 3'b010, 32'h0,   32'hCAFEF00D);
        addBeat(HtNonseq, 1'b1, 3'b010, 32'h02,  32'h0BADBAD0);
        addBeat(HtNonseq, 1'b1, 3'b010, 32'h400, 32'h0BADBAD1);
        addBeat(HtNonseq, 1'b1, 3'b011, 32'h0,   32'h0BADBAD2);
        addBeat(HtNonseq, 1'b1, 3'b001, 32'h1,   32'h0BADBAD3);
        addBeat(HtNonseq, 1'b0, 3'b010, 32'h0,   32'h0);
        runBeats();
    endtask

    task automatic test_back_to_back();
        useFast = 1'b1;
        addBeat(HtNonseq, 1'b1, 3'b010, 32'h8, 32'h5A5A5A5A);
        addBeat(HtNonseq, 1'b0, 3'b010, 32'h8, 32'h0);
        addBeat(HtNonseq, 1'b1, 3'b010, 32'hC, 32'h01020304);
        addBeat(HtNonseq, 1'b1, 3'b000, 32'hD, 32'h0000EE00);
        addBeat(HtNonseq, 1'b0, 3'b010, 32'hC, 32'h0);
        addBeat(HtNonseq, 1'b0, 3'b010, 32'h8, 32'h0);
        runBeats();
        useFast = 1'b0;
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_burst();
        test_error();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Global watchdog in case the bench itself stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
